// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Widest bus the request struct carries; arbiter widths must not exceed these.
    localparam int MEM_AWIDTH       = 32;
    localparam int MEM_DWIDTH       = 32;
    localparam int MEM_SWIDTH       = MEM_DWIDTH / 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_IF,
        PORT_D
    } port_sel_e;

    typedef struct packed {
        logic [MEM_AWIDTH-1:0] addr;
        logic [MEM_DWIDTH-1:0] wdata;
        logic [MEM_SWIDTH-1:0] wstrb;
        logic                  we;
    } mem_req_t;

    // Saturating increment of the fetch-starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt == lim) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory bus of the arbiter, bundled for port lists.
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    localparam int SWIDTH = DWIDTH / 8;

    // fetch request / response
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [AWIDTH-1:0] if_addr_i;
    logic              if_rsp_valid_o;
    logic [DWIDTH-1:0] if_rsp_data_o;
    logic              if_rsp_ready_i;

    // data request / response
    logic              d_req_valid_i;
    logic              d_req_ready_o;
    logic [AWIDTH-1:0] d_addr_i;
    logic [DWIDTH-1:0] d_wdata_i;
    logic [SWIDTH-1:0] d_wstrb_i;
    logic              d_we_i;
    logic              d_rsp_valid_o;
    logic [DWIDTH-1:0] d_rsp_data_o;
    logic              d_rsp_ready_i;

    // memory side
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic [SWIDTH-1:0] mem_write_strb_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;
    logic              mem_data_vld_i;

    // arbiter side
    modport slave (
        input  if_req_valid_i, if_addr_i, if_rsp_ready_i,
        input  d_req_valid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_we_i, d_rsp_ready_i,
        input  mem_data_i, mem_data_vld_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
        output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
        output mem_addr_o, mem_data_o, mem_write_strb_o, mem_read_en_o, mem_write_en_o
    );

    // requesters + memory side
    modport master (
        output if_req_valid_i, if_addr_i, if_rsp_ready_i,
        output d_req_valid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_we_i, d_rsp_ready_i,
        output mem_data_i, mem_data_vld_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
        input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
        input  mem_addr_o, mem_data_o, mem_write_strb_o, mem_read_en_o, mem_write_en_o
    );
endinterface

// File: rtl/mem_arbiter_rsp_slot.sv
// One-entry response holding register: loaded on a grant, drained on ready.
module rsp_slot #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] load_data_i,
    input  logic              rsp_ready_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              free_o
);
    logic              vld_q;
    logic [DWIDTH-1:0] data_q;

    // Load wins over drain so a drain and refill on the same edge keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= load_data_i;
        end else if (rsp_ready_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign rsp_valid_o = vld_q;
    assign rsp_data_o  = data_q;
    // Slot can accept a new result at the coming edge.
    assign free_o      = !vld_q || rsp_ready_i;
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-cycle memory with fetch anti-starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = MEM_AWIDTH,
    parameter int DWIDTH       = MEM_DWIDTH,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int          SWIDTH = DWIDTH / 8;
    localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);

    port_sel_e         sel;
    mem_req_t          mem_req;
    logic              if_free, d_free;
    logic              if_elig, d_elig;
    logic              if_slot_vld, d_slot_vld;
    logic [3:0]        starve_cnt;
    logic [DWIDTH-1:0] d_load_data;
    logic              unused_vld;

    // The memory is single-cycle, so its valid strobe carries no information.
    assign unused_vld = bus.mem_data_vld_i;

    assign if_elig = bus.if_req_valid_i && if_free && !rst;
    assign d_elig  = bus.d_req_valid_i  && d_free  && !rst;

    // Grant select: data has priority until fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        sel = PORT_NONE;
        if (if_elig && d_elig)
            sel = (starve_cnt == LIMIT) ? PORT_IF : PORT_D;
        else if (if_elig)
            sel = PORT_IF;
        else if (d_elig)
            sel = PORT_D;
    end

    // Build the memory request of the granted port; idle bus is all zero.
    always_comb begin
        mem_req = '0;
        unique case (sel)
            PORT_IF: mem_req.addr = MEM_AWIDTH'(bus.if_addr_i);
            PORT_D: begin
                mem_req.addr  = MEM_AWIDTH'(bus.d_addr_i);
                mem_req.wdata = MEM_DWIDTH'(bus.d_wdata_i);
                mem_req.wstrb = MEM_SWIDTH'(bus.d_wstrb_i);
                mem_req.we    = bus.d_we_i;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o       = mem_req.addr[AWIDTH-1:0];
    assign bus.mem_data_o       = mem_req.wdata[DWIDTH-1:0];
    assign bus.mem_write_strb_o = mem_req.wstrb[SWIDTH-1:0];
    assign bus.mem_read_en_o    = (sel != PORT_NONE) && !mem_req.we;
    assign bus.mem_write_en_o   = (sel == PORT_D) && mem_req.we;
    assign bus.if_req_ready_o   = (sel == PORT_IF);
    assign bus.d_req_ready_o    = (sel == PORT_D);

    // Stores complete with a zero-data response.
    assign d_load_data = mem_req.we ? '0 : bus.mem_data_i;

    // Count consecutive data wins while fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (sel == PORT_IF || !if_elig)
            starve_cnt <= '0;
        else if (sel == PORT_D)
            starve_cnt <= starve_inc(starve_cnt, LIMIT);
    end

    rsp_slot #(.DWIDTH(DWIDTH)) u_if_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sel == PORT_IF),
        .load_data_i (bus.mem_data_i),
        .rsp_ready_i (bus.if_rsp_ready_i),
        .rsp_valid_o (if_slot_vld),
        .rsp_data_o  (bus.if_rsp_data_o),
        .free_o      (if_free)
    );

    rsp_slot #(.DWIDTH(DWIDTH)) u_d_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sel == PORT_D),
        .load_data_i (d_load_data),
        .rsp_ready_i (bus.d_rsp_ready_i),
        .rsp_valid_o (d_slot_vld),
        .rsp_data_o  (bus.d_rsp_data_o),
        .free_o      (d_free)
    );

    // A result captured just before reset is not offered while reset is held.
    assign bus.if_rsp_valid_o = if_slot_vld && !rst;
    assign bus.d_rsp_valid_o  = d_slot_vld  && !rst;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a model.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, LIM = 2;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, bad = 0;
    logic [31:0] mem [0:255];

    mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic in_rng(input logic [31:0] a);
        return a[31:10] == BASE[31:10];
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return in_rng(a) ? mem[a[9:2]] : 32'hDEAD_BEEF;
    endfunction

    // memory model: combinational read, byte-strobed write at the edge
    always_comb begin
        bus.mem_data_i     = rd(bus.mem_addr_o);
        bus.mem_data_vld_i = bus.mem_read_en_o;
    end

    always @(posedge clk) begin
        if (bus.mem_write_en_o && in_rng(bus.mem_addr_o))
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_strb_o[b]) mem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.if_req_valid_i = 0; bus.if_addr_i = 0; bus.if_rsp_ready_i = 1;
        bus.d_req_valid_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.d_wstrb_i = 0; bus.d_we_i = 0;
        bus.d_rsp_ready_i = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        bus.if_req_valid_i = 1; bus.if_addr_i = BASE;
        bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 32'h40; bus.d_we_i = 1; bus.d_wstrb_i = 4'hF; bus.d_wdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.if_req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_if_ready got=%b exp=0", bus.if_req_ready_o); end
        total++; if (bus.d_req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b exp=0", bus.d_req_ready_o); end
        total++; if ({bus.mem_read_en_o, bus.mem_write_en_o} !== 2'b00) begin bad++; $display("FAIL reset_mem_en got=%b exp=00", {bus.mem_read_en_o, bus.mem_write_en_o}); end
        total++; if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr_o); end
        total++; if ({bus.if_rsp_valid_o, bus.d_rsp_valid_o} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {bus.if_rsp_valid_o, bus.d_rsp_valid_o}); end
        total++; if ({bus.if_rsp_data_o, bus.d_rsp_data_o} !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", {bus.if_rsp_data_o, bus.d_rsp_data_o}); end
        @(posedge clk); #1;
        idle(); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        bus.if_req_valid_i = 1; bus.if_addr_i = BASE;
        @(negedge clk);
        total++; if (bus.if_req_ready_o !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b exp=1", bus.if_req_ready_o); end
        total++; if ({bus.mem_read_en_o, bus.mem_write_en_o} !== 2'b10) begin bad++; $display("FAIL fetch_en got=%b exp=10", {bus.mem_read_en_o, bus.mem_write_en_o}); end
        total++; if (bus.mem_addr_o !== BASE) begin bad++; $display("FAIL fetch_addr got=%h exp=%h", bus.mem_addr_o, BASE); end
        total++; if (bus.mem_write_strb_o !== 4'h0) begin bad++; $display("FAIL fetch_strb got=%h exp=0", bus.mem_write_strb_o); end
        @(posedge clk); #1;
        bus.if_req_valid_i = 0;
        @(negedge clk);
        total++; if (bus.if_rsp_valid_o !== 1'b1) begin bad++; $display("FAIL fetch_rsp_valid got=%b exp=1", bus.if_rsp_valid_o); end
        total++; if (bus.if_rsp_data_o !== 32'h0050_0093) begin bad++; $display("FAIL fetch_rsp_data got=%h exp=00500093", bus.if_rsp_data_o); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.if_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL fetch_rsp_drained got=%b exp=0", bus.if_rsp_valid_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 32'h10; bus.d_wdata_i = 32'hCAFE_F00D; bus.d_wstrb_i = 4'hF; bus.d_we_i = 1;
        @(negedge clk);
        total++; if (bus.d_req_ready_o !== 1'b1) begin bad++; $display("FAIL store_ready got=%b exp=1", bus.d_req_ready_o); end
        total++; if ({bus.mem_read_en_o, bus.mem_write_en_o} !== 2'b01) begin bad++; $display("FAIL store_en got=%b exp=01", {bus.mem_read_en_o, bus.mem_write_en_o}); end
        total++; if ({bus.mem_addr_o, bus.mem_data_o, bus.mem_write_strb_o} !== {BASE + 32'h10, 32'hCAFE_F00D, 4'hF}) begin
            bad++; $display("FAIL store_bus got=%h/%h/%h exp=%h/cafef00d/f", bus.mem_addr_o, bus.mem_data_o, bus.mem_write_strb_o, BASE + 32'h10); end
        @(posedge clk); #1;
        bus.d_we_i = 0; bus.d_wdata_i = 0; bus.d_wstrb_i = 0;
        @(negedge clk);
        total++; if ({bus.d_rsp_valid_o, bus.d_rsp_data_o} !== {1'b1, 32'h0}) begin bad++; $display("FAIL store_rsp got=%b/%h exp=1/0", bus.d_rsp_valid_o, bus.d_rsp_data_o); end
        total++; if ({bus.d_req_ready_o, bus.mem_read_en_o, bus.mem_write_en_o} !== 3'b110) begin bad++; $display("FAIL load_grant got=%b exp=110", {bus.d_req_ready_o, bus.mem_read_en_o, bus.mem_write_en_o}); end
        @(posedge clk); #1;
        bus.d_req_valid_i = 0;
        @(negedge clk);
        total++; if ({bus.d_rsp_valid_o, bus.d_rsp_data_o} !== {1'b1, 32'hCAFE_F00D}) begin bad++; $display("FAIL load_rsp got=%b/%h exp=1/cafef00d", bus.d_rsp_valid_o, bus.d_rsp_data_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_starve();
        int expect_if;
        bus.if_req_valid_i = 1; bus.if_addr_i = BASE + 32'h20;
        bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 32'h30; bus.d_we_i = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            // every (LIM+1)-th grant goes to fetch
            expect_if = ((k % (LIM + 1)) == LIM) ? 1 : 0;
            total++; if ({bus.if_req_ready_o, bus.d_req_ready_o} !== (expect_if ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL starve_order cyc=%0d got if/d=%b exp if=%0d", k, {bus.if_req_ready_o, bus.d_req_ready_o}, expect_if); end
            @(posedge clk); #1;
            if (expect_if != 0) bus.if_addr_i = BASE + 4 * $urandom_range(0, 15);
            else                bus.d_addr_i  = BASE + 4 * $urandom_range(0, 15);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, held;
        a = BASE + 32'h8; b = BASE + 32'hC;
        bus.if_req_valid_i = 1; bus.if_addr_i = a; bus.if_rsp_ready_i = 0;
        @(negedge clk);
        total++; if (bus.if_req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_first_grant got=%b exp=1", bus.if_req_ready_o); end
        held = rd(a);
        @(posedge clk); #1;
        bus.if_addr_i = b;
        for (int k = 0; k < 3; k++) begin
            bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 4 * $urandom_range(16, 31); bus.d_we_i = 0;
            @(negedge clk);
            total++; if ({bus.if_rsp_valid_o, bus.if_rsp_data_o} !== {1'b1, held}) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", k, bus.if_rsp_valid_o, bus.if_rsp_data_o, held); end
            total++; if ({bus.if_req_ready_o, bus.d_req_ready_o} !== 2'b01) begin bad++; $display("FAIL bp_grant cyc=%0d got if/d=%b exp=01", k, {bus.if_req_ready_o, bus.d_req_ready_o}); end
            @(posedge clk); #1;
        end
        bus.d_req_valid_i = 0; bus.if_rsp_ready_i = 1;
        @(negedge clk);
        total++; if (bus.if_req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_drain_refill got=%b exp=1", bus.if_req_ready_o); end
        @(posedge clk); #1;
        bus.if_req_valid_i = 0;
        @(negedge clk);
        total++; if ({bus.if_rsp_valid_o, bus.if_rsp_data_o} !== {1'b1, rd(b)}) begin bad++; $display("FAIL bp_second_rsp got=%b/%h exp=1/%h", bus.if_rsp_valid_o, bus.if_rsp_data_o, rd(b)); end
        @(posedge clk); #1;
    endtask

    task automatic test_oob();
        bus.d_req_valid_i = 1; bus.d_addr_i = 32'h0000_0004; bus.d_we_i = 0;
        @(posedge clk); #1;
        bus.d_req_valid_i = 0;
        @(negedge clk);
        total++; if ({bus.d_rsp_valid_o, bus.d_rsp_data_o} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL oob_rsp got=%b/%h exp=1/deadbeef", bus.d_rsp_valid_o, bus.d_rsp_data_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        old = mem[8];
        bus.if_req_valid_i = 1; bus.if_addr_i = BASE + 32'h4;
        @(negedge clk);
        total++; if (bus.if_req_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%b exp=1", bus.if_req_ready_o); end
        @(posedge clk); #1;
        rst = 1; bus.if_req_valid_i = 0;
        bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 32'h20; bus.d_we_i = 1; bus.d_wstrb_i = 4'hF; bus.d_wdata_i = ~old;
        @(negedge clk);
        total++; if ({bus.d_req_ready_o, bus.mem_write_en_o, bus.if_rsp_valid_o} !== 3'b000) begin bad++; $display("FAIL rmid_in_reset got=%b exp=000", {bus.d_req_ready_o, bus.mem_write_en_o, bus.if_rsp_valid_o}); end
        @(posedge clk); #1;
        rst = 0; idle();
        @(negedge clk);
        total++; if ({bus.if_rsp_valid_o, bus.d_rsp_valid_o} !== 2'b00) begin bad++; $display("FAIL rmid_after got=%b exp=00", {bus.if_rsp_valid_o, bus.d_rsp_valid_o}); end
        @(posedge clk); #1;
        bus.d_req_valid_i = 1; bus.d_addr_i = BASE + 32'h20; bus.d_we_i = 0;
        bus.if_req_valid_i = 1; bus.if_addr_i = BASE + 32'h4;
        @(negedge clk);
        total++; if (bus.d_req_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_post_grant got=%b exp=1", bus.d_req_ready_o); end
        @(posedge clk); #1;
        bus.d_req_valid_i = 0;
        @(negedge clk);
        total++; if ({bus.d_rsp_valid_o, bus.d_rsp_data_o} !== {1'b1, old}) begin bad++; $display("FAIL rmid_no_write got=%b/%h exp=1/%h", bus.d_rsp_valid_o, bus.d_rsp_data_o, old); end
        total++; if (bus.if_req_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_post_fetch got=%b exp=1", bus.if_req_ready_o); end
        @(posedge clk); #1;
        bus.if_req_valid_i = 0;
        @(negedge clk);
        total++; if ({bus.if_rsp_valid_o, bus.if_rsp_data_o} !== {1'b1, rd(BASE + 32'h4)}) begin bad++; $display("FAIL rmid_post_rsp got=%b/%h exp=1/%h", bus.if_rsp_valid_o, bus.if_rsp_data_o, rd(BASE + 32'h4)); end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 9) == 0) ? 32'h0000_0004 * $urandom_range(0, 7) : BASE + 4 * $urandom_range(0, 15);
    endfunction

    // Reference model: one pending response per port, data wins unless fetch has lost LIM times running.
    task automatic test_random();
        logic [31:0] q_if [$];
        logic [31:0] q_d [$];
        int  streak = 0;
        bit  hold_if = 0, hold_d = 0;
        bit  e_if, e_d, g_if, g_d;
        rst = 1; idle();
        @(posedge clk); #1;
        rst = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold_if) begin
                bus.if_req_valid_i = ($urandom_range(0, 3) != 0);
                bus.if_addr_i = rand_addr();
            end
            if (!hold_d) begin
                bus.d_req_valid_i = ($urandom_range(0, 3) != 0);
                bus.d_addr_i = rand_addr();
                bus.d_we_i = $urandom_range(0, 2) == 0;
                bus.d_wdata_i = $urandom;
                bus.d_wstrb_i = 4'($urandom_range(0, 15));
            end
            bus.if_rsp_ready_i = ($urandom_range(0, 9) < 7);
            bus.d_rsp_ready_i  = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            e_if = bus.if_req_valid_i && (q_if.size() == 0 || bus.if_rsp_ready_i);
            e_d  = bus.d_req_valid_i  && (q_d.size()  == 0 || bus.d_rsp_ready_i);
            g_if = e_if && (!e_d || streak == LIM);
            g_d  = e_d && !g_if;
            total++; if ({bus.if_req_ready_o, bus.d_req_ready_o} !== {g_if, g_d}) begin
                bad++; $display("FAIL rnd_grant cyc=%0d got if/d=%b exp=%b", cyc, {bus.if_req_ready_o, bus.d_req_ready_o}, {g_if, g_d}); end
            total++; if ({bus.mem_read_en_o, bus.mem_write_en_o} !== {g_if || (g_d && !bus.d_we_i), g_d && bus.d_we_i}) begin
                bad++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", cyc, {bus.mem_read_en_o, bus.mem_write_en_o}, {g_if || (g_d && !bus.d_we_i), g_d && bus.d_we_i}); end
            total++; if ({bus.if_rsp_valid_o, bus.d_rsp_valid_o} !== {q_if.size() != 0, q_d.size() != 0}) begin
                bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, {bus.if_rsp_valid_o, bus.d_rsp_valid_o}, {q_if.size() != 0, q_d.size() != 0}); end
            if (q_if.size() != 0) begin
                total++; if (bus.if_rsp_data_o !== q_if[0]) begin bad++; $display("FAIL rnd_if_data cyc=%0d got=%h exp=%h", cyc, bus.if_rsp_data_o, q_if[0]); end
                if (bus.if_rsp_ready_i) void'(q_if.pop_front());
            end
            if (q_d.size() != 0) begin
                total++; if (bus.d_rsp_data_o !== q_d[0]) begin bad++; $display("FAIL rnd_d_data cyc=%0d got=%h exp=%h", cyc, bus.d_rsp_data_o, q_d[0]); end
                if (bus.d_rsp_ready_i) void'(q_d.pop_front());
            end
            if (g_if) q_if.push_back(rd(bus.if_addr_i));
            if (g_d)  q_d.push_back(bus.d_we_i ? 32'h0 : rd(bus.d_addr_i));
            if (g_if || !e_if) streak = 0;
            else if (g_d && streak < LIM) streak++;
            hold_if = bus.if_req_valid_i && !g_if;
            hold_d  = bus.d_req_valid_i && !g_d;
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        idle();
        test_reset();
        test_fetch();
        test_store_load();
        test_starve();
        test_backpressure();
        test_oob();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Param AWIDTH, 32, address width.
REQ-002 Param DWIDTH, 32, data width; strobe width DWIDTH/8.
REQ-003 Param STARVE_LIMIT, 4, max consecutive data grants while fetch waits (range 1..15).
REQ-004 Ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-005 Fetch request ports: if_req_valid_i (in, 1, fetch request); if_req_ready_o (out, 1, fetch accepted); if_addr_i (in, AWIDTH, fetch address).
REQ-006 Fetch response ports: if_rsp_valid_o (out, 1, fetch response); if_rsp_data_o (out, DWIDTH, fetched word); if_rsp_ready_i (in, 1, fetch consumer ready).
REQ-007 Data request ports: d_req_valid_i (in, 1, load/store request); d_req_ready_o (out, 1, request accepted); d_addr_i (in, AWIDTH, address); d_wdata_i (in, DWIDTH, store data); d_wstrb_i (in, DWIDTH/8, byte strobes); d_we_i (in, 1, 1 = store).
REQ-008 Data response ports: d_rsp_valid_o (out, 1, response); d_rsp_data_o (out, DWIDTH, load data, 0 for store); d_rsp_ready_i (in, 1, consumer ready).
REQ-009 Memory address/data outputs: mem_addr_o (out, AWIDTH); mem_data_o (out, DWIDTH); mem_write_strb_o (out, DWIDTH/8).
REQ-010 Memory control and return: mem_read_en_o (out, 1); mem_write_en_o (out, 1); mem_data_i (in, DWIDTH, combinational read data); mem_data_vld_i (in, 1).

Function
REQ-011 Port eligible = req_valid & (rsp slot empty | rsp_ready this cycle).
REQ-012 At most one grant per cycle; ready_o is combinational and equals that port's grant; transfer occurs on valid & ready.
REQ-013 Only one port eligible -> that port is granted.
REQ-014 Both eligible -> data granted unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
REQ-015 starve_cnt: +1 on data grant while fetch eligible and not granted; cleared on fetch grant or when fetch not eligible; saturates at STARVE_LIMIT.
REQ-016 Granted request drives the memory combinationally in the same cycle: mem_addr_o = addr; read_en = !we; write_en = we (data port only); mem_data_o/strb from the data port.
REQ-017 Fetch grants drive strb = 0 and write_en = 0.
REQ-018 No grant -> mem_addr_o, mem_data_o and strb are 0; both enables are 0.
REQ-019 On a read grant, mem_data_i is captured into the granted port's response slot at the next edge (latency 1 cycle); out-of-range data 0xDEADBEEF passes through unmodified.
REQ-020 On a store grant, the slot is loaded with data 0 so that a completion response is generated.
REQ-021 rsp_valid is held with stable data until rsp_ready; slot drain and refill on the same edge are allowed, giving throughput 1 per cycle.
REQ-022 mem_data_vld_i is ignored for sequencing; the memory is single-cycle.
REQ-023 Requesters hold stable while valid & !ready; violations are unchecked.
REQ-024 No grant may occur during rst.

Reset
REQ-025 On rst at the clock edge: both rsp_valid = 0, rsp_data = 0, starve_cnt = 0; requests in flight are dropped; no memory write is issued in the reset cycle.

Structure
REQ-026 The shared package mem_arb_pkg holds the port-select enum {PORT_NONE, PORT_IF, PORT_D}, the default STARVE_LIMIT, and the mem_req_t struct (addr, wdata, wstrb, we).
REQ-027 One sub-module rsp_slot (1-entry valid/data holding register with load/drain) is instantiated twice, once per port.

Verification (memory at 0x01000000, STARVE_LIMIT = 2)
REQ-028 Lone fetch to 0x01000000 whose word is 0x00500093 -> ready in same cycle, read_en = 1, if_rsp_valid next cycle with data 0x00500093.
REQ-029 Store 0xCAFEF00D to 0x01000010 with wstrb 0xF, then load of the same address -> write_en pulse, d_rsp data 0, then load returns 0xCAFEF00D.
REQ-030 Fetch and data both valid every cycle -> grant order D, D, IF, D, D, IF; starve_cnt never exceeds 2.
REQ-031 if_rsp_ready_i = 0 for 3 cycles with a fetch pending -> response is held stable, no new fetch grant, and the data port is still served.
REQ-032 Load from 0x00000004 -> d_rsp data 0xDEADBEEF.
REQ-033 rst asserted in the cycle after a grant -> rsp_valid is 0 next cycle, no response is delivered, and post-reset requests behave normally.
